uio_bus_arbiter: RTL

Round-robin arbiter that shares the 8-bit bidirectional uio pad bank between N_REQ internal requesters inside a tt_um user module. It grants exclusive ownership of the pads to one requester at a time and inserts guaranteed turnaround cycles with all output enables low between owners. It also bounds ownership time, and registers pad direction, drive data and sampled input data. It sits between the user datapath blocks (counters, mux logic) and the top-level uio_out/uio_oe/uio_in ports.

---
 rtl/uio_bus_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/uio_bus_arbiter.sv
// Round-robin owner of the shared uio pad bank. Guarantees turnaround gaps with
// all pad enables low between owners, bounds hold time, registers pad paths.
module uio_bus_arbiter #(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 8,
  parameter int TURN_CYC = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ-1:0]     wr,
  input  logic [8*N_REQ-1:0]   wdata,
  output logic [N_REQ-1:0]     gnt,
  input  logic [7:0]           uio_in,
  output logic [7:0]           uio_out,
  output logic [7:0]           uio_oe,
  output logic [7:0]           rdata,
  output logic                 rdata_vld,
  output logic                 busy
);

  localparam int         IW       = (N_REQ > 2) ? $clog2(N_REQ) : 1;
  localparam logic [3:0] TURN_LD  = 4'(TURN_CYC);
  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

  typedef enum logic [1:0] {ST_IDLE, ST_TURN, ST_OWN} state_t;

  logic             rst_ni_q;
  state_t           state_q;
  logic [IW-1:0]    owner_q;
  logic [IW-1:0]    last_q;
  logic [3:0]       turn_q;
  logic [7:0]       hold_q;
  logic [N_REQ-1:0] gnt_q;
  logic [7:0]       oe_q;
  logic [7:0]       out_q;
  logic [7:0]       rdata_q;
  logic             vld_q;

  logic [7:0]       hold_d;
  logic [N_REQ-1:0] others_d;
  logic [IW-1:0]    pick_idle_d;
  logic [IW-1:0]    pick_rel_d;
  logic             release_d;
  logic             wr_sel_d;
  logic [7:0]       wdata_sel_d;

  // First set bit of mask, searching upward from base+1 and wrapping to base.
  function automatic logic [IW-1:0] rr_pick(input logic [N_REQ-1:0] mask,
                                            input logic [IW-1:0]    base);
    logic [IW-1:0] pick;
    logic [IW-1:0] idx;
    logic          found;
    pick  = base;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = IW'((int'(base) + k) % N_REQ);
      if (!found && mask[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Internal reset: clears with rst_n, releases on the first edge afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_ni_q <= 1'b0;
    else        rst_ni_q <= 1'b1;
  end

  always_comb begin
    others_d    = req & ~(N_REQ'(1) << owner_q);
    pick_idle_d = rr_pick(req, last_q);
    pick_rel_d  = rr_pick(others_d, owner_q);
    hold_d      = (hold_q >= HOLD_LIM) ? hold_q : hold_q + 8'd1;
    // hold_d counts the current cycle, so an owner gets exactly MAX_HOLD cycles
    release_d   = !req[owner_q] || ((hold_d == HOLD_LIM) && (|others_d));
    wr_sel_d    = wr[owner_q];
    wdata_sel_d = wdata[{owner_q, 3'b000} +: 8];
  end

  always_ff @(posedge clk or negedge rst_ni_q) begin
    if (!rst_ni_q) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      last_q  <= IW'(N_REQ - 1);
      turn_q  <= '0;
      hold_q  <= '0;
      gnt_q   <= '0;
      oe_q    <= 8'h00;
      out_q   <= 8'h00;
      rdata_q <= 8'h00;
      vld_q   <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (|req) begin
            owner_q <= pick_idle_d;
            turn_q  <= TURN_LD;
            state_q <= ST_TURN;
          end
        end
        ST_TURN: begin
          if (turn_q <= 4'd1) begin
            if (req[owner_q]) begin
              state_q <= ST_OWN;
              gnt_q   <= N_REQ'(1) << owner_q;
              last_q  <= owner_q;
              hold_q  <= 8'd0;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            turn_q <= turn_q - 4'd1;
          end
        end
        ST_OWN: begin
          if (release_d) begin
            gnt_q <= '0;
            oe_q  <= 8'h00;
            out_q <= 8'h00;
            if (|others_d) begin
              owner_q <= pick_rel_d;
              turn_q  <= TURN_LD;
              state_q <= ST_TURN;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            hold_q <= hold_d;
            oe_q   <= wr_sel_d ? 8'hFF : 8'h00;
            out_q  <= wr_sel_d ? wdata_sel_d : 8'h00;
            if (!wr_sel_d) begin
              rdata_q <= uio_in;
              vld_q   <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign uio_oe    = oe_q;
  assign uio_out   = out_q;
  assign rdata     = rdata_q;
  assign rdata_vld = vld_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
